mem_router: RTL and testbench

Parametrised successor to the single-target memory front end: routes Vicuna/Ibex data-memory requests to `NUM_SLV` address-decoded slave ports through a request FIFO. It sits between the vproc memory interface and the storage/timer/GPIO blocks. It adds a per-slave grant handshake, per-region read-only protection, decode errors and a response timeout. One transaction is outstanding on the slave side at a time.

---
 rtl/mem_router.sv | 224 ++++++++++++++++++++++
 tb/tb_mem_router.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_router.sv
// mem_router: routes core data-memory requests through a small request FIFO
// to NUM_SLV address-decoded slave ports, one slave transaction at a time.
// Decode misses, writes to read-only regions, slave errors and slave
// timeouts all come back to the core as err=1 responses with zero rdata.
//
// state | meaning
// IDLE  | waiting for a FIFO head; decodes it and pops it into the capture regs
// ISSUE | slv_req held to the target until it grants (or the timer expires)
// WAIT  | granted; waiting for the target's rvalid (or the timer expires)
// RESP  | one-cycle response pulse back to the core
module mem_router #(
    parameter int                     MEM_W     = 32,
    parameter int                     NUM_SLV   = 4,
    parameter logic [NUM_SLV*32-1:0]  SLV_BASE  = {NUM_SLV{32'h0}},
    parameter logic [NUM_SLV*32-1:0]  SLV_MASK  = {NUM_SLV{32'hFFFF_F000}},
    parameter logic [NUM_SLV-1:0]     SLV_RO    = '0,
    parameter int                     REQ_DEPTH = 2,
    parameter int                     TIMEOUT   = 255
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     vproc_mem_req_o,
    input  logic [31:0]              vproc_mem_addr_o,
    input  logic                     vproc_mem_we_o,
    input  logic [MEM_W/8-1:0]       vproc_mem_be_o,
    input  logic [MEM_W-1:0]         vproc_mem_wdata_o,
    output logic                     vproc_mem_rvalid_i,
    output logic                     vproc_mem_err_i,
    output logic [MEM_W-1:0]         vproc_mem_rdata_i,
    output logic [NUM_SLV-1:0]       slv_req,
    output logic [31:0]              slv_addr,
    output logic                     slv_we,
    output logic [MEM_W/8-1:0]       slv_be,
    output logic [MEM_W-1:0]         slv_wdata,
    input  logic [NUM_SLV-1:0]       slv_gnt,
    input  logic [NUM_SLV-1:0]       slv_rvalid,
    input  logic [NUM_SLV-1:0]       slv_err,
    input  logic [NUM_SLV*MEM_W-1:0] slv_rdata,
    output logic                     busy,
    output logic                     req_overflow
);

    localparam int BE_W  = MEM_W / 8;
    localparam int PTR_W = $clog2(REQ_DEPTH);
    localparam int TGT_W = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;
    localparam int CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
    localparam logic [PTR_W:0]   DEPTH_L  = (PTR_W + 1)'(REQ_DEPTH);
    // The transition out of ISSUE/WAIT happens on the edge where the count
    // reaches TIMEOUT, so the slave side is occupied exactly TIMEOUT cycles.
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    state_t state, state_next;

    logic [31:0]      fifo_addr  [REQ_DEPTH];
    logic             fifo_we    [REQ_DEPTH];
    logic [BE_W-1:0]  fifo_be    [REQ_DEPTH];
    logic [MEM_W-1:0] fifo_wdata [REQ_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [PTR_W:0]   count;
    logic             empty, full, push, pop;

    logic [31:0]      cap_addr;
    logic             cap_we;
    logic [BE_W-1:0]  cap_be;
    logic [MEM_W-1:0] cap_wdata;
    logic [TGT_W-1:0] tgt;

    logic             hit;
    logic [TGT_W-1:0] hit_idx;
    logic [31:0]      head_addr;
    logic             head_we;

    logic [CNT_W-1:0] tmo_cnt;
    logic             tmo_fire, cnt_clr;

    logic             rsp_load, rsp_err_d, rsp_err;
    logic [MEM_W-1:0] rsp_rdata_d, rsp_rdata, tgt_rdata;
    logic             overflow;

    assign empty     = (count == '0);
    assign full      = (count == DEPTH_L);
    assign push      = vproc_mem_req_o && (!full || pop);
    assign head_addr = fifo_addr[rd_ptr];
    assign head_we   = fifo_we[rd_ptr];
    assign tmo_fire  = (tmo_cnt == TMO_LAST);
    assign tgt_rdata = slv_rdata[tgt*MEM_W +: MEM_W];

    // FIFO storage; contents are don't-care while the pointers say empty.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr[wr_ptr]  <= vproc_mem_addr_o;
            fifo_we[wr_ptr]    <= vproc_mem_we_o;
            fifo_be[wr_ptr]    <= vproc_mem_be_o;
            fifo_wdata[wr_ptr] <= vproc_mem_wdata_o;
        end
    end

    // FIFO pointers, occupancy and the sticky overflow flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
            if (vproc_mem_req_o && full && !pop) overflow <= 1'b1;
        end
    end

    // Address decode of the FIFO head; the descending scan lets the lowest
    // matching region win when regions overlap.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = NUM_SLV - 1; i >= 0; i--) begin
            if ((head_addr & SLV_MASK[32*i +: 32]) == SLV_BASE[32*i +: 32]) begin
                hit     = 1'b1;
                hit_idx = TGT_W'(i);
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_next;
    end

    // FSM next state plus pop / timer-clear / response-load strobes.
    always_comb begin
        state_next  = state;
        pop         = 1'b0;
        cnt_clr     = 1'b0;
        rsp_load    = 1'b0;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = '0;
        case (state)
            S_IDLE: begin
                if (!empty) begin
                    pop = 1'b1;
                    if (!hit || (head_we && SLV_RO[hit_idx])) begin
                        state_next = S_RESP;
                        rsp_load   = 1'b1;
                        rsp_err_d  = 1'b1;
                    end else begin
                        state_next = S_ISSUE;
                        cnt_clr    = 1'b1;
                    end
                end
            end
            S_ISSUE: begin
                if (slv_gnt[tgt]) begin
                    state_next = S_WAIT;
                end else if (tmo_fire) begin
                    state_next = S_RESP;
                    rsp_load   = 1'b1;
                    rsp_err_d  = 1'b1;
                end
            end
            S_WAIT: begin
                if (slv_rvalid[tgt]) begin
                    state_next  = S_RESP;
                    rsp_load    = 1'b1;
                    rsp_err_d   = slv_err[tgt];
                    rsp_rdata_d = (cap_we || slv_err[tgt]) ? '0 : tgt_rdata;
                end else if (tmo_fire) begin
                    state_next = S_RESP;
                    rsp_load   = 1'b1;
                    rsp_err_d  = 1'b1;
                end
            end
            S_RESP: state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Capture register, target index, response latches and slave-side timer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cap_addr  <= '0;
            cap_we    <= 1'b0;
            cap_be    <= '0;
            cap_wdata <= '0;
            tgt       <= '0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
            tmo_cnt   <= '0;
        end else begin
            if (pop) begin
                cap_addr  <= head_addr;
                cap_we    <= head_we;
                cap_be    <= fifo_be[rd_ptr];
                cap_wdata <= fifo_wdata[rd_ptr];
                tgt       <= hit_idx;
            end
            if (rsp_load) begin
                rsp_err   <= rsp_err_d;
                rsp_rdata <= rsp_rdata_d;
            end
            if (cnt_clr)
                tmo_cnt <= '0;
            else if (state == S_ISSUE || state == S_WAIT)
                tmo_cnt <= tmo_cnt + 1'b1;
        end
    end

    assign slv_req            = (state == S_ISSUE) ? (NUM_SLV'(1) << tgt) : '0;
    assign slv_addr           = cap_addr;
    assign slv_we             = cap_we;
    assign slv_be             = cap_be;
    assign slv_wdata          = cap_wdata;
    assign vproc_mem_rvalid_i = (state == S_RESP);
    assign vproc_mem_err_i    = vproc_mem_rvalid_i & rsp_err;
    assign vproc_mem_rdata_i  = vproc_mem_rvalid_i ? rsp_rdata : '0;
    assign busy               = !empty || (state != S_IDLE);
    assign req_overflow       = overflow;

endmodule

// File: tb/tb_mem_router.sv
// Bench for mem_router: table of single transactions plus hand-written
// sequences for timeout, back-to-back overflow and reset in WAIT.
module tb_mem_router;

    localparam logic [127:0] KEYS = {32'h3333_3333, 32'h2222_2222, 32'hDEAD_BEEF, 32'h1111_0000};

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         mem_req = 1'b0;
    logic [31:0]  mem_addr = '0;
    logic         mem_we = 1'b0;
    logic [3:0]   mem_be = '0;
    logic [31:0]  mem_wdata = '0;
    logic         rsp_valid, rsp_err;
    logic [31:0]  rsp_rdata;
    logic [3:0]   slv_req;
    logic [31:0]  slv_addr;
    logic         slv_we;
    logic [3:0]   slv_be;
    logic [31:0]  slv_wdata;
    logic [3:0]   slv_gnt = '0;
    logic [3:0]   slv_rvalid = '0;
    logic [3:0]   slv_err = '0;
    logic [127:0] slv_rdata;
    logic         busy, req_overflow;

    always #5 clk = ~clk;

    assign slv_rdata = KEYS;

    mem_router #(
        .MEM_W(32), .NUM_SLV(4),
        .SLV_BASE({32'h0001_0000, 32'h0000_2000, 32'h0000_1000, 32'h0001_0000}),
        .SLV_MASK({32'hFFFF_0000, 32'hFFFF_F000, 32'hFFFF_F000, 32'hFFFF_F000}),
        .SLV_RO(4'b1000), .REQ_DEPTH(2), .TIMEOUT(8)
    ) dut (
        .clk(clk), .rst(rst),
        .vproc_mem_req_o(mem_req), .vproc_mem_addr_o(mem_addr), .vproc_mem_we_o(mem_we),
        .vproc_mem_be_o(mem_be), .vproc_mem_wdata_o(mem_wdata),
        .vproc_mem_rvalid_i(rsp_valid), .vproc_mem_err_i(rsp_err), .vproc_mem_rdata_i(rsp_rdata),
        .slv_req(slv_req), .slv_addr(slv_addr), .slv_we(slv_we), .slv_be(slv_be),
        .slv_wdata(slv_wdata), .slv_gnt(slv_gnt), .slv_rvalid(slv_rvalid),
        .slv_err(slv_err), .slv_rdata(slv_rdata),
        .busy(busy), .req_overflow(req_overflow)
    );

    // slave model configuration, written by the test
    int         gnt_dly = 0;
    bit         never_gnt = 1'b0;
    bit         never_rv = 1'b0;
    logic [3:0] serr = '0;
    logic [3:0] inj_rv = '0;

    int req_cnt [4];
    bit pend_rv [4];

    // Slave model: grant after gnt_dly extra request cycles, respond the next cycle.
    always @(negedge clk) begin
        slv_gnt    = '0;
        slv_rvalid = '0;
        slv_err    = '0;
        for (int i = 0; i < 4; i++) begin
            if (!rst) begin
                req_cnt[i] = 0;
                pend_rv[i] = 1'b0;
            end else begin
                if (pend_rv[i]) begin
                    slv_rvalid[i] = 1'b1;
                    slv_err[i]    = serr[i];
                    pend_rv[i]    = 1'b0;
                end
                if (slv_req[i]) begin
                    if (!never_gnt && req_cnt[i] == gnt_dly) begin
                        slv_gnt[i] = 1'b1;
                        req_cnt[i] = 0;
                        pend_rv[i] = !never_rv;
                    end else begin
                        req_cnt[i]++;
                    end
                end else begin
                    req_cnt[i] = 0;
                end
            end
        end
        slv_rvalid = slv_rvalid | inj_rv;
    end

    typedef struct packed {
        logic        err;
        logic [31:0] rdata;
    } exp_t;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [3:0]  serr;
        logic        err;
        logic [31:0] rdata;
        logic [3:0]  tgt;
        int          lat;
    } vec_t;

    exp_t        sb_q[$];
    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          rsp_count = 0;
    int          last_rsp_cyc = 0;
    int          req_cycles [4] = '{0, 0, 0, 0};
    logic [31:0] pay_addr = '0;
    logic        pay_we = 1'b0;
    logic [3:0]  pay_be = '0;
    logic [31:0] pay_wdata = '0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // One cycle: sample DUT outputs at the falling edge, score responses.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        cyc++;
        if (slv_req != '0) begin
            for (int i = 0; i < 4; i++) if (slv_req[i]) req_cycles[i]++;
            pay_addr  = slv_addr;
            pay_we    = slv_we;
            pay_be    = slv_be;
            pay_wdata = slv_wdata;
            check("slv_req_onehot", 128'($countones(slv_req)), 128'd1);
        end
        if (rsp_valid) begin
            rsp_count++;
            last_rsp_cyc = cyc;
            check("rsp_expected", 128'(sb_q.size() > 0), 128'd1);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check("rsp_err", 128'(rsp_err), 128'(e.err));
                check("rsp_rdata", 128'(rsp_rdata), 128'(e.rdata));
            end
        end
        #1;
    endtask

    task automatic drive(input logic [31:0] a, input logic w, input logic [3:0] b,
                         input logic [31:0] d, output int t0);
        mem_req   = 1'b1;
        mem_addr  = a;
        mem_we    = w;
        mem_be    = b;
        mem_wdata = d;
        t0        = cyc;
        tick();
        mem_req   = 1'b0;
    endtask

    task automatic wait_rsp(input int target, input int budget);
        int n;
        n = 0;
        while (rsp_count < target && n < budget) begin
            tick();
            n++;
        end
        check("rsp_within_bound", 128'(rsp_count >= target), 128'd1);
    endtask

    task automatic expect_rsp(input logic err, input logic [31:0] rdata);
        exp_t e;
        e.err   = err;
        e.rdata = rdata;
        sb_q.push_back(e);
    endtask

    vec_t vecs [10];

    initial begin
        int t0;
        int target;
        int snap [4];
        logic [3:0] seen;

        //          addr          we    be      wdata         serr     err   rdata          tgt      lat
        vecs[0] = '{32'h0000_1004, 1'b0, 4'hF,   32'h0,        4'b0000, 1'b0, 32'hDEAD_BEEF, 4'b0010, 4};
        vecs[1] = '{32'h0000_0050, 1'b0, 4'hF,   32'h0,        4'b0000, 1'b1, 32'h0,         4'b0000, 2};
        vecs[2] = '{32'h0001_1000, 1'b1, 4'hF,   32'hCAFE_0001, 4'b0000, 1'b1, 32'h0,         4'b0000, 2};
        vecs[3] = '{32'h0001_1000, 1'b0, 4'hF,   32'h0,        4'b0000, 1'b0, 32'h3333_3333, 4'b1000, 4};
        vecs[4] = '{32'h0001_0010, 1'b1, 4'b0011, 32'h1234_5678, 4'b0000, 1'b0, 32'h0,       4'b0001, 4};
        vecs[5] = '{32'h0000_2008, 1'b1, 4'b1100, 32'hA5A5_0000, 4'b0100, 1'b1, 32'h0,       4'b0100, 4};
        vecs[6] = '{32'h0000_2FFC, 1'b0, 4'hF,   32'h0,        4'b0000, 1'b0, 32'h2222_2222, 4'b0100, 4};
        vecs[7] = '{32'h0000_3000, 1'b0, 4'hF,   32'h0,        4'b0000, 1'b1, 32'h0,         4'b0000, 2};
        vecs[8] = '{32'h0000_0FFC, 1'b0, 4'hF,   32'h0,        4'b0000, 1'b1, 32'h0,         4'b0000, 2};
        vecs[9] = '{32'h0001_FFFC, 1'b0, 4'hF,   32'h0,        4'b0000, 1'b0, 32'h3333_3333, 4'b1000, 4};

        repeat (3) tick();
        check("rst_busy", 128'(busy), 128'd0);
        check("rst_slv_req", 128'(slv_req), 128'd0);
        rst = 1'b1;
        tick();
        check("idle_outputs", {busy, rsp_valid, rsp_err, rsp_rdata, slv_req, req_overflow, slv_addr},
              128'd0);

        // table of single transactions
        for (int v = 0; v < 10; v++) begin
            serr   = vecs[v].serr;
            snap   = req_cycles;
            target = rsp_count + 1;
            expect_rsp(vecs[v].err, vecs[v].rdata);
            drive(vecs[v].addr, vecs[v].we, vecs[v].be, vecs[v].wdata, t0);
            wait_rsp(target, 20);
            check("latency", 128'(last_rsp_cyc - t0), 128'(vecs[v].lat));
            seen = '0;
            for (int i = 0; i < 4; i++) if (req_cycles[i] != snap[i]) seen[i] = 1'b1;
            check("target_mask", 128'(seen), 128'(vecs[v].tgt));
            if (vecs[v].tgt != '0)
                check("payload", {pay_addr, pay_we, pay_be, pay_wdata},
                      {vecs[v].addr, vecs[v].we, vecs[v].be, vecs[v].wdata});
            tick();
        end
        serr = '0;

        // slave never grants: timeout after 8 request cycles, late rvalid ignored
        never_gnt = 1'b1;
        snap      = req_cycles;
        target    = rsp_count + 1;
        expect_rsp(1'b1, 32'h0);
        drive(32'h0000_1004, 1'b0, 4'hF, 32'h0, t0);
        wait_rsp(target, 20);
        check("tmo_latency", 128'(last_rsp_cyc - t0), 128'd10);
        check("tmo_req_cycles", 128'(req_cycles[1] - snap[1]), 128'd8);
        never_gnt = 1'b0;
        inj_rv = 4'b0010;
        tick();
        inj_rv = '0;
        repeat (4) tick();
        check("late_rvalid_ignored", 128'(rsp_count), 128'(target));

        // slow slave, four requests back to back: fourth dropped
        gnt_dly = 5;
        check("ovf_clear_before", 128'(req_overflow), 128'd0);
        target = rsp_count + 3;
        expect_rsp(1'b0, 32'h1111_0000);
        expect_rsp(1'b0, 32'hDEAD_BEEF);
        expect_rsp(1'b0, 32'h2222_2222);
        drive(32'h0001_0000, 1'b0, 4'hF, 32'h0, t0);
        drive(32'h0000_1004, 1'b0, 4'hF, 32'h0, t0);
        drive(32'h0000_2000, 1'b0, 4'hF, 32'h0, t0);
        drive(32'h0000_1008, 1'b0, 4'hF, 32'h0, t0);
        check("ovf_set", 128'(req_overflow), 128'd1);
        wait_rsp(target, 60);
        check("busy_at_last_rsp", 128'(busy), 128'd1);
        tick();
        check("busy_after_last_rsp", 128'(busy), 128'd0);
        repeat (12) tick();
        check("dropped_no_rsp", 128'(rsp_count), 128'(target));
        check("ovf_sticky", 128'(req_overflow), 128'd1);
        gnt_dly = 0;

        // reset while waiting for a slave that never answers
        never_rv = 1'b1;
        target   = rsp_count;
        drive(32'h0000_2000, 1'b0, 4'hF, 32'h0, t0);
        repeat (3) tick();
        check("busy_in_wait", 128'(busy), 128'd1);
        rst = 1'b0;
        #1;
        check("rst_async_outputs", {busy, rsp_valid, slv_req, req_overflow, slv_addr}, 128'd0);
        tick();
        tick();
        rst      = 1'b1;
        never_rv = 1'b0;
        inj_rv   = 4'b0100;
        tick();
        inj_rv = '0;
        repeat (3) tick();
        check("no_stale_rsp", 128'(rsp_count), 128'(target));
        target = rsp_count + 1;
        expect_rsp(1'b0, 32'hDEAD_BEEF);
        drive(32'h0000_1004, 1'b0, 4'hF, 32'h0, t0);
        wait_rsp(target, 20);
        check("post_rst_latency", 128'(last_rsp_cyc - t0), 128'd4);
        check("sb_drained", 128'(sb_q.size()), 128'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
